// File: rtl/chacha_pkg.sv
// chacha_pkg: shared types and constants for the ChaCha inverse round engine.
//   word_t   : 32-bit ChaCha word
//   state_t  : 16-word state, word i occupies bits [32*i +: 32]
//   COL_IDX  : word indices of the four column quarter-round groups
//   DIAG_IDX : word indices of the four diagonal quarter-round groups
//   SIGMA    : "expand 32-byte k" constants (words 0..3 of a fresh block)
//   rotr/rotl: 32-bit rotate helpers
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] state_t;
  typedef logic [3:0]  widx_t;

  localparam widx_t COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam widx_t DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  localparam word_t SIGMA [4] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_inv_permute_if.sv
// chacha_inv_permute_if: valid/ready bundle for the inverse round engine.
//   in_valid/in_ready/state_in    : block input handshake and permuted state
//   out_valid/out_ready/state_out : recovered state handshake
//   master : producer/consumer side (drives in_valid, state_in, out_ready)
//   slave  : engine side
interface chacha_inv_permute_if;
  import chacha_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t state_in;
  logic   out_valid;
  logic   out_ready;
  state_t state_out;

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/chacha_inv_quarterround.sv
// chacha_inv_quarterround: combinational inverse of one ChaCha quarter round.
//   a, b, c, d         : words after the forward quarter round
//   a_prev .. d_prev   : words before the forward quarter round
// All arithmetic wraps mod 2^32.
module chacha_inv_quarterround
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_prev,
  output word_t b_prev,
  output word_t c_prev,
  output word_t d_prev
);

  word_t a1, b1, c1, d1;

  // Undo the forward sequence back to front: each line reverses one
  // add/xor/rotate triple of the forward quarter round.
  always_comb begin
    b1     = rotr(b, 7) ^ c;
    c1     = c - d;
    d1     = rotr(d, 8) ^ a;
    a1     = a - b1;
    b_prev = rotr(b1, 12) ^ c1;
    c_prev = c1 - d1;
    d_prev = rotr(d1, 16) ^ a1;
    a_prev = a1 - b_prev;
  end

endmodule

// File: rtl/chacha_inv_permute.sv
// chacha_inv_permute: iterative inverse of ROUNDS forward ChaCha rounds
// (no feed-forward add). One inverse half-round per cycle, or two when
// CHACHA_INV_UNROLL2_EN is defined (diagonal then column chained).
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset, aborts any block in flight
//   bus  : slave side of chacha_inv_permute_if (input/output handshakes)
// Parameter ROUNDS: forward rounds to undo, even and >= 2.
module chacha_inv_permute
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  chacha_inv_permute_if.slave  bus
);

`ifdef CHACHA_INV_UNROLL2_EN
  localparam int NSTAGE = 2;
`else
  localparam int NSTAGE = 1;
`endif
  localparam int CW = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t          fsm_reg, fsm_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  state_t        state_reg, state_next;
  logic          out_valid_reg, out_valid_next;
  state_t        state_step;

  // Chain of NSTAGE half-rounds. Inverse step j is diagonal for even j and
  // column for odd j, because the last forward round of an even count is a
  // diagonal round. Stage si of a cycle performs step cnt_reg + si.
  for (genvar si = 0; si < NSTAGE; si++) begin : g_stage
    localparam logic SI_ODD = (si % 2) == 1;
    state_t s_in, s_out;
    word_t  qin  [4][4];
    word_t  qout [4][4];
    logic   odd;

    if (si == 0) begin : g_first
      assign s_in = state_reg;
    end else begin : g_chain
      assign s_in = g_stage[si-1].s_out;
    end

    assign odd = cnt_reg[0] ^ SI_ODD;

    always_comb begin
      for (int g = 0; g < 4; g++) begin
        for (int k = 0; k < 4; k++) begin
          qin[g][k] = odd ? s_in[COL_IDX[g][k]] : s_in[DIAG_IDX[g][k]];
        end
      end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_qr
      chacha_inv_quarterround u_qr (
        .a      (qin[gi][0]),
        .b      (qin[gi][1]),
        .c      (qin[gi][2]),
        .d      (qin[gi][3]),
        .a_prev (qout[gi][0]),
        .b_prev (qout[gi][1]),
        .c_prev (qout[gi][2]),
        .d_prev (qout[gi][3])
      );
    end

    // Groups are disjoint and cover all 16 words, so every word is rewritten.
    always_comb begin
      s_out = s_in;
      for (int g = 0; g < 4; g++) begin
        for (int k = 0; k < 4; k++) begin
          if (odd) s_out[COL_IDX[g][k]]  = qout[g][k];
          else     s_out[DIAG_IDX[g][k]] = qout[g][k];
        end
      end
    end
  end

  assign state_step = g_stage[NSTAGE-1].s_out;

  always_comb begin
    fsm_next       = fsm_reg;
    cnt_next       = cnt_reg;
    state_next     = state_reg;
    out_valid_next = out_valid_reg;
    case (fsm_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = bus.state_in;
          cnt_next   = '0;
          fsm_next   = RUN;
        end
      end
      RUN: begin
        state_next = state_step;
        cnt_next   = cnt_reg + CW'(NSTAGE);
        if (cnt_reg == CW'(ROUNDS - NSTAGE)) begin
          fsm_next       = DONE;
          out_valid_next = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          fsm_next       = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg       <= IDLE;
      cnt_reg       <= '0;
      state_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      fsm_reg       <= fsm_next;
      cnt_reg       <= cnt_next;
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign bus.in_ready  = (fsm_reg == IDLE) && !rst;
  assign bus.out_valid = out_valid_reg;
  assign bus.state_out = state_reg;

endmodule
